// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-RAM arbiter between the MEM stage (P) and the
// program/debug loader (D).
package dmem_arb_pkg;

  localparam int unsigned StarveMaxDefault = 4;
  localparam int unsigned WordAwDefault    = 8;

  // Which requester the read data arriving this cycle belongs to.
  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnP    = 2'd1,
    OwnD    = 2'd2
  } owner_t;

  // Word-aligned and inside the 4*2^aw byte window.
  function automatic logic word_addr_ok(input logic [31:0] addr, input int unsigned aw);
    logic [31:0] hi;
    hi = addr >> (aw + 2);
    return (addr[1:0] == 2'b00) && (hi == 32'd0);
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Fixed-priority arbiter for the single-port data RAM: P wins unless D has been starved for
// STARVE_MAX cycles. Read data returns one cycle later to whichever port issued the read.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = StarveMaxDefault,
  parameter int unsigned WORD_AW    = WordAwDefault
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               p_req,
  input  logic               p_we,
  input  logic [31:0]        p_addr,
  input  logic [31:0]        p_wdata,
  output logic               p_gnt,
  output logic               p_rvalid,
  output logic [31:0]        p_rdata,

  input  logic               d_req,
  input  logic               d_we,
  input  logic [31:0]        d_addr,
  input  logic [31:0]        d_wdata,
  output logic               d_gnt,
  output logic               d_rvalid,
  output logic [31:0]        d_rdata,

  output logic               err,

  output logic [WORD_AW-1:0] mem_addr,
  output logic [31:0]        mem_wdata,
  output logic               mem_we,
  input  logic [31:0]        mem_rdata
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic [3:0]  starve_q, starve_d;
  owner_t      rd_owner_q, rd_owner_d;
  logic        err_q, err_d;

  logic        any_gnt;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        addr_ok;

  // Grant: starved D first, then P, then D. Nothing is granted while reset is held.
  always_comb begin
    p_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst_n) begin
      if (d_req && (starve_q == StarveMax)) begin
        d_gnt = 1'b1;
      end else if (p_req) begin
        p_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    any_gnt   = p_gnt | d_gnt;
    sel_we    = 1'b0;
    sel_addr  = 32'd0;
    sel_wdata = 32'd0;
    if (p_gnt) begin
      sel_we    = p_we;
      sel_addr  = p_addr;
      sel_wdata = p_wdata;
    end else if (d_gnt) begin
      sel_we    = d_we;
      sel_addr  = d_addr;
      sel_wdata = d_wdata;
    end
    addr_ok = word_addr_ok(sel_addr, WORD_AW);
  end

  // A bad address is still granted so the requester never stalls, but it never reaches RAM.
  always_comb begin
    mem_addr  = sel_addr[WORD_AW+1:2];
    mem_wdata = sel_wdata;
    mem_we    = any_gnt && sel_we && addr_ok;
  end

  always_comb begin
    starve_d = starve_q;
    if (!d_req || d_gnt) begin
      starve_d = 4'd0;
    end else if (starve_q != StarveMax) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    rd_owner_d = OwnNone;
    if (any_gnt && !sel_we && addr_ok) begin
      rd_owner_d = p_gnt ? OwnP : OwnD;
    end
  end

  assign err_d = err_q | (any_gnt & ~addr_ok);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q   <= 4'd0;
      rd_owner_q <= OwnNone;
      err_q      <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      rd_owner_q <= rd_owner_d;
      err_q      <= err_d;
    end
  end

  // Gating with rst_n drops a response whose read was issued just before reset asserted.
  always_comb begin
    p_rvalid = rst_n && (rd_owner_q == OwnP);
    d_rvalid = rst_n && (rd_owner_q == OwnD);
    p_rdata  = p_rvalid ? mem_rdata : 32'd0;
    d_rdata  = d_rvalid ? mem_rdata : 32'd0;
  end

  assign err = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural one-cycle-latency RAM attached.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p_req, p_we, d_req, d_we;
  logic [31:0] p_addr, p_wdata, d_addr, d_wdata;
  logic        p_gnt, p_rvalid, d_gnt, d_rvalid;
  logic [31:0] p_rdata, d_rdata;
  logic        err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  int n_vec;
  int n_err;

  logic [31:0] ram [256];

  dmem_arbiter #(
    .STARVE_MAX(4),
    .WORD_AW   (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .p_req    (p_req),
    .p_we     (p_we),
    .p_addr   (p_addr),
    .p_wdata  (p_wdata),
    .p_gnt    (p_gnt),
    .p_rvalid (p_rvalid),
    .p_rdata  (p_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .err      (err),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic idle();
    p_req = 1'b0; p_we = 1'b0; p_addr = 32'd0; p_wdata = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
  endtask

  // Advance to just after the next rising edge, then let combinational outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic p_rd(input logic [31:0] a);
    p_req = 1'b1; p_we = 1'b0; p_addr = a; p_wdata = 32'd0;
  endtask

  task automatic d_rd(input logic [31:0] a);
    d_req = 1'b1; d_we = 1'b0; d_addr = a; d_wdata = 32'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    p_rd(32'h0);
    d_rd(32'h4);
    #3;
    n_vec++;
    if ({p_gnt, d_gnt} !== 2'b00) begin
      n_err++; $display("FAIL reset_gnt: got %b want 00", {p_gnt, d_gnt});
    end
    n_vec++;
    if (mem_we !== 1'b0) begin
      n_err++; $display("FAIL reset_we: got %b want 0", mem_we);
    end
    tick();
    #2;
    n_vec++;
    if ({p_rvalid, d_rvalid, err} !== 3'b000) begin
      n_err++; $display("FAIL reset_rvalid_err: got %b want 000", {p_rvalid, d_rvalid, err});
    end
    n_vec++;
    if ({p_rdata, d_rdata} !== 64'd0) begin
      n_err++; $display("FAIL reset_rdata: got %h/%h want 0/0", p_rdata, d_rdata);
    end
    rst_n = 1'b1;
    idle();
    tick();
  endtask

  task automatic test_write_read();
    p_req = 1'b1; p_we = 1'b1; p_addr = 32'h10; p_wdata = 32'hDEAD_BEEF;
    #2;
    n_vec++;
    if ({p_gnt, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 8'd4, 32'hDEAD_BEEF}) begin
      n_err++;
      $display("FAIL wr_issue: got gnt=%b we=%b a=%h d=%h want 1 1 04 deadbeef",
               p_gnt, mem_we, mem_addr, mem_wdata);
    end
    tick();
    p_rd(32'h10);
    #2;
    n_vec++;
    if ({p_gnt, mem_we, mem_addr} !== {1'b1, 1'b0, 8'd4}) begin
      n_err++;
      $display("FAIL rd_issue: got gnt=%b we=%b a=%h want 1 0 04", p_gnt, mem_we, mem_addr);
    end
    n_vec++;
    if (p_rvalid !== 1'b0) begin
      n_err++; $display("FAIL wr_no_resp: got p_rvalid=%b want 0", p_rvalid);
    end
    tick();
    idle();
    #2;
    n_vec++;
    if ({p_rvalid, p_rdata, d_rvalid, d_rdata} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL rd_resp: got p=%b/%h d=%b/%h want 1/deadbeef 0/0",
               p_rvalid, p_rdata, d_rvalid, d_rdata);
    end
    tick();
  endtask

  task automatic test_starvation();
    p_rd(32'h20);
    d_rd(32'h0);
    for (int i = 1; i <= 4; i++) begin
      #2;
      n_vec++;
      if ({p_gnt, d_gnt} !== 2'b10) begin
        n_err++; $display("FAIL starve_deny%0d: got %b want 10", i, {p_gnt, d_gnt});
      end
      tick();
    end
    #2;
    n_vec++;
    if ({p_gnt, d_gnt, mem_addr} !== {2'b01, 8'd0}) begin
      n_err++; $display("FAIL starve_grant: got %b a=%h want 01 a=00", {p_gnt, d_gnt}, mem_addr);
    end
    tick();
    d_req = 1'b0;
    #2;
    n_vec++;
    if ({p_gnt, d_gnt} !== 2'b10) begin
      n_err++; $display("FAIL starve_p_regain: got %b want 10", {p_gnt, d_gnt});
    end
    n_vec++;
    if ({d_rvalid, d_rdata, p_rvalid} !== {1'b1, 32'h1111_0000, 1'b0}) begin
      n_err++;
      $display("FAIL starve_d_resp: got d=%b/%h p=%b want 1/11110000 0",
               d_rvalid, d_rdata, p_rvalid);
    end
    // A fresh D request must wait the full four cycles again.
    tick();
    d_rd(32'h0);
    for (int i = 1; i <= 4; i++) begin
      #2;
      n_vec++;
      if ({p_gnt, d_gnt} !== 2'b10) begin
        n_err++; $display("FAIL starve_rearm%0d: got %b want 10", i, {p_gnt, d_gnt});
      end
      tick();
    end
    #2;
    n_vec++;
    if ({p_gnt, d_gnt} !== 2'b01) begin
      n_err++; $display("FAIL starve_rearm_grant: got %b want 01", {p_gnt, d_gnt});
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_drop_clears();
    p_rd(32'h20);
    d_rd(32'h0);
    tick(); tick(); tick();
    d_req = 1'b0;
    tick();
    d_rd(32'h0);
    for (int i = 1; i <= 4; i++) begin
      #2;
      n_vec++;
      if ({p_gnt, d_gnt} !== 2'b10) begin
        n_err++; $display("FAIL drop_deny%0d: got %b want 10", i, {p_gnt, d_gnt});
      end
      tick();
    end
    #2;
    n_vec++;
    if ({p_gnt, d_gnt} !== 2'b01) begin
      n_err++; $display("FAIL drop_grant: got %b want 01", {p_gnt, d_gnt});
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_interleaved();
    p_rd(32'h0);
    tick();
    idle();
    d_rd(32'h4);
    #2;
    n_vec++;
    if ({p_rvalid, p_rdata, d_rvalid} !== {1'b1, 32'h1111_0000, 1'b0}) begin
      n_err++;
      $display("FAIL il_p0: got p=%b/%h d=%b want 1/11110000 0", p_rvalid, p_rdata, d_rvalid);
    end
    tick();
    idle();
    p_rd(32'h8);
    #2;
    n_vec++;
    if ({d_rvalid, d_rdata, p_rvalid, p_rdata} !== {1'b1, 32'h2222_0001, 1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL il_d1: got d=%b/%h p=%b/%h want 1/22220001 0/0",
               d_rvalid, d_rdata, p_rvalid, p_rdata);
    end
    tick();
    idle();
    #2;
    n_vec++;
    if ({p_rvalid, p_rdata, d_rvalid, d_rdata} !== {1'b1, 32'h3333_0002, 1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL il_p2: got p=%b/%h d=%b/%h want 1/33330002 0/0",
               p_rvalid, p_rdata, d_rvalid, d_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    p_rd(32'h8);
    tick();
    p_rd(32'h4);
    #2;
    n_vec++;
    if ({p_rvalid, p_rdata} !== {1'b1, 32'h3333_0002}) begin
      n_err++; $display("FAIL b2b_first: got %b/%h want 1/33330002", p_rvalid, p_rdata);
    end
    tick();
    idle();
    #2;
    n_vec++;
    if ({p_rvalid, p_rdata} !== {1'b1, 32'h2222_0001}) begin
      n_err++; $display("FAIL b2b_second: got %b/%h want 1/22220001", p_rvalid, p_rdata);
    end
    tick();
  endtask

  task automatic test_bad_addr();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h6; d_wdata = 32'hBAD0_BAD0;
    #2;
    n_vec++;
    if ({d_gnt, mem_we, err} !== 3'b100) begin
      n_err++; $display("FAIL bad_mis_issue: got gnt=%b we=%b err=%b want 1 0 0", d_gnt, mem_we, err);
    end
    tick();
    d_rd(32'h400);
    #2;
    n_vec++;
    if ({err, d_rvalid} !== 2'b10) begin
      n_err++; $display("FAIL bad_mis_err: got err=%b rvalid=%b want 1 0", err, d_rvalid);
    end
    n_vec++;
    if ({d_gnt, mem_we} !== 2'b10) begin
      n_err++; $display("FAIL bad_oor_issue: got gnt=%b we=%b want 1 0", d_gnt, mem_we);
    end
    tick();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'hCAFE_F00D;
    #2;
    n_vec++;
    if ({d_rvalid, d_rdata, err} !== {1'b0, 32'd0, 1'b1}) begin
      n_err++; $display("FAIL bad_oor_resp: got rv=%b rd=%h err=%b want 0 0 1", d_rvalid, d_rdata, err);
    end
    n_vec++;
    if ({mem_we, mem_addr} !== {1'b1, 8'd2}) begin
      n_err++; $display("FAIL good_wr_issue: got we=%b a=%h want 1 02", mem_we, mem_addr);
    end
    tick();
    d_rd(32'h8);
    tick();
    d_rd(32'h4);
    #2;
    n_vec++;
    if ({d_rvalid, d_rdata, err} !== {1'b1, 32'hCAFE_F00D, 1'b1}) begin
      n_err++;
      $display("FAIL good_rd_resp: got %b/%h err=%b want 1/cafef00d 1", d_rvalid, d_rdata, err);
    end
    tick();
    idle();
    #2;
    n_vec++;
    if ({d_rvalid, d_rdata} !== {1'b1, 32'h2222_0001}) begin
      n_err++; $display("FAIL bad_no_write: got %b/%h want 1/22220001", d_rvalid, d_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    p_rd(32'h0);
    #2;
    n_vec++;
    if (p_gnt !== 1'b1) begin
      n_err++; $display("FAIL rmr_gnt: got %b want 1", p_gnt);
    end
    tick();
    idle();
    rst_n = 1'b0;
    #2;
    n_vec++;
    if ({p_rvalid, p_rdata} !== {1'b0, 32'd0}) begin
      n_err++; $display("FAIL rmr_suppress: got %b/%h want 0/0", p_rvalid, p_rdata);
    end
    tick();
    #2;
    n_vec++;
    if ({err, p_rvalid} !== 2'b00) begin
      n_err++; $display("FAIL rmr_clear: got err=%b rv=%b want 0 0", err, p_rvalid);
    end
    rst_n = 1'b1;
    tick();
    p_rd(32'h4);
    tick();
    idle();
    #2;
    n_vec++;
    if ({p_rvalid, p_rdata} !== {1'b1, 32'h2222_0001}) begin
      n_err++; $display("FAIL rmr_after: got %b/%h want 1/22220001", p_rvalid, p_rdata);
    end
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) ram[i] = 32'd0;
    ram[0] = 32'h1111_0000;
    ram[1] = 32'h2222_0001;
    ram[2] = 32'h3333_0002;
    rst_n = 1'b0;
    idle();
    tick();
    test_reset();
    test_write_read();
    test_starvation();
    test_drop_clears();
    test_interleaved();
    test_back_to_back();
    test_bad_addr();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data RAM between the pipeline MEM stage (port P) and the program/debug loader (port D). Each cycle it grants at most one requester, drives the RAM's word address, write data and write enable, and routes the one-cycle-latency read data back to the requester that issued the read. P has priority; a starvation counter forces a D grant after a bounded wait. Byte addresses are checked for alignment and range before any RAM access.

## Interface
- STARVE_MAX, 4: consecutive denied D cycles after which D is granted over P (1..15)
- WORD_AW, 8: RAM word-address width; legal byte addresses are 0 .. 4*2^WORD_AW-1
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- p_req / d_req  in  1  access request, held until granted
- p_we / d_we  in  1  1 = write, 0 = read
- p_addr / d_addr  in  32  byte address
- p_wdata / d_wdata  in  32  write data
- p_gnt / d_gnt  out  1  combinational grant, same cycle as request
- p_rvalid / d_rvalid  out  1  registered; read data valid this cycle
- p_rdata / d_rdata  out  32  read data, equals mem_rdata when rvalid, else 0
- err  out  1  sticky: a granted access had a misaligned or out-of-range address
- mem_addr  out  WORD_AW  RAM word address = granted addr[WORD_AW+1:2]
- mem_wdata  out  32  granted write data
- mem_we  out  1  RAM write enable
- mem_rdata  in  32  RAM q output, valid one cycle after address sampled

## Operation
- Grant: if rst_n=0, no grant. Else if d_req and starve_cnt==STARVE_MAX, D. Else if p_req, P. Else if d_req, D. Else none.
- starve_cnt (4 bits): +1 when d_req && !d_gnt, saturating at STARVE_MAX; cleared when d_gnt or !d_req.
- Address check on granted request: bad = addr[1:0]!=0 or addr[31:WORD_AW+2]!=0. A bad access is still granted (the requester is not stalled), but mem_we is forced to 0, no rvalid is issued, and err is set. err clears only on reset.
- Write: mem_we = gnt && we && !bad. No response is returned.
- Read: rd_owner register ∈ {NONE, P, D} is set to the granted requester on a good read, otherwise NONE. In the next cycle the matching rvalid is 1 and its rdata = mem_rdata; the other port's rdata = 0.
- When no grant: mem_addr, mem_wdata = 0 and mem_we = 0.
- Back-to-back reads from either port are supported at one per cycle; responses stay in issue order.

## Timing
- Reset values: rd_owner=NONE, starve_cnt=0, err=0. Therefore p_rvalid = d_rvalid = 0 and rdata = 0; gnt = 0 and mem_we = 0 while rst_n=0.
- Grant-to-address: 0 cycles. Read latency: request in cycle N, rvalid in N+1.
- Worst-case D wait under continuous P traffic is STARVE_MAX cycles; D is granted in cycle STARVE_MAX+1.
- Reset asserted in cycle N+1 after a read in N: the rvalid for that read is suppressed.
- A D request dropped before its grant clears starve_cnt.

## Structure
- Package dmem_arb_pkg:
  - owner_t enum (NONE, P, D)
  - STARVE_MAX default
  - a function word_addr_ok(addr, WORD_AW)
- Single module. No sub-module; the grant logic, counter and response register are small.
- The RAM is instantiated outside this block; mem_* ports connect directly to it, clocked by clk.

## Test plan
- Reset check: rst_n=0 with p_req=d_req=1 -> p_gnt=d_gnt=0, mem_we=0, err=0; all rvalid=0 in the following cycle.
- P writes 0xDEADBEEF to 0x10, then reads 0x10 -> mem_addr=4 with mem_we=1; next P read returns p_rvalid=1 and p_rdata=0xDEADBEEF one cycle later.
- Continuous p_req with d_req held -> D is denied for 4 cycles, d_gnt=1 in the 5th cycle, then starve_cnt=0 and P regains the grant.
- Interleaved reads P@0x0, D@0x4, P@0x8 -> rvalid alternates p, d, p in order, each with the matching data.
- D write to 0x6 (misaligned) or 0x400 (out of range, WORD_AW=8) -> d_gnt=1, mem_we=0, err=1 sticky, no rvalid; a subsequent good access proceeds normally.
- Read granted, then rst_n=0 in the next cycle -> no rvalid; after reset release the first read behaves normally.
